// File: rtl/mano_pkg.sv
// mano_pkg: shared encodings for the basic-computer control unit, ALU and
// datapath. Holds the opcode, ALU select, bus select and E-flag operation
// encodings plus the bit positions inside the REG_LD / REG_INR vectors.
package mano_pkg;

    localparam int W_DEF = 16;
    localparam int NT    = 7;      // T0..T6 are the only decoded T-states

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_ADD    = 3'd1,
        OP_LDA    = 3'd2,
        OP_STA    = 3'd3,
        OP_BUN    = 3'd4,
        OP_BSA    = 3'd5,
        OP_ISZ    = 3'd6,
        OP_REG_IO = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_AND  = 3'b001,
        ALU_XFER = 3'b010,
        ALU_CMA  = 3'b011,
        ALU_SHR  = 3'b100,
        ALU_SHL  = 3'b101
    } alu_sel_e;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    typedef enum logic [2:0] {
        E_HOLD    = 3'd0,
        E_CLR     = 3'd1,
        E_CMP     = 3'd2,
        E_LD_CO   = 3'd3,
        E_LD_AC0  = 3'd4,
        E_LD_ACMS = 3'd5
    } e_op_e;

    // REG_LD = {IR,AC,DR,PC,AR}
    localparam int LD_AR = 0;
    localparam int LD_PC = 1;
    localparam int LD_DR = 2;
    localparam int LD_AC = 3;
    localparam int LD_IR = 4;

    // REG_INR = {AC,DR,PC,AR}
    localparam int INR_AR = 0;
    localparam int INR_PC = 1;
    localparam int INR_DR = 2;
    localparam int INR_AC = 3;

    // Register-reference bits should be one-hot; if several are set the
    // highest one is kept. Ascending scan so the last (highest) hit wins.
    function automatic logic [11:0] rr_pick(input logic [11:0] b);
        logic [11:0] r;
        r = '0;
        for (int k = 0; k < 12; k++) begin
            if (b[k]) r = 12'(1) << k;
        end
        return r;
    endfunction

endpackage

// File: rtl/mano_control_unit_if.sv
// mano_control_unit_if: control-unit <-> datapath signal bundle.
//   master : control unit (consumes IR/status/START, drives control strobes)
//   slave  : datapath side (drives IR/status/START, consumes strobes)
// Signals: START, IR[W], AC_ZERO, AC_MSB, E, DR_ZERO in to the controller;
// ALU_SEL, BUS_SEL, REG_LD, REG_INR, AC_CLR, MEM_RD, MEM_WR, E_OP, HALTED,
// SC_OUT out of it.
interface mano_control_unit_if #(
    parameter int W = 16
);
    logic         START;
    logic [W-1:0] IR;
    logic         AC_ZERO;
    logic         AC_MSB;
    logic         E;
    logic         DR_ZERO;
    logic [2:0]   ALU_SEL;
    logic [2:0]   BUS_SEL;
    logic [4:0]   REG_LD;
    logic [3:0]   REG_INR;
    logic         AC_CLR;
    logic         MEM_RD;
    logic         MEM_WR;
    logic [2:0]   E_OP;
    logic         HALTED;
    logic [3:0]   SC_OUT;

    modport master (
        input  START, IR, AC_ZERO, AC_MSB, E, DR_ZERO,
        output ALU_SEL, BUS_SEL, REG_LD, REG_INR, AC_CLR, MEM_RD, MEM_WR,
               E_OP, HALTED, SC_OUT
    );

    modport slave (
        output START, IR, AC_ZERO, AC_MSB, E, DR_ZERO,
        input  ALU_SEL, BUS_SEL, REG_LD, REG_INR, AC_CLR, MEM_RD, MEM_WR,
               E_OP, HALTED, SC_OUT
    );
endinterface

// File: rtl/mano_seq_counter.sv
// mano_seq_counter: 4-bit sequence counter SC with clear / hold / increment
// (clear beats hold beats increment) and a one-hot decode of T0..T(NT-1).
//   clk, rst_n : clock, async active-low reset (SC -> 0)
//   clr        : SC <= 0 on next edge
//   hold       : SC keeps its value
//   sc         : current T-state
//   t          : one-hot T-state decode
module mano_seq_counter
    import mano_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          hold,
    output logic [3:0]    sc,
    output logic [NT-1:0] t
);
    logic [3:0] sc_q, sc_d;

    always_comb begin
        sc_d = sc_q + 4'd1;
        if (clr)       sc_d = 4'd0;
        else if (hold) sc_d = sc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sc_q <= 4'd0;
        else        sc_q <= sc_d;
    end

    always_comb begin
        t = '0;
        for (int k = 0; k < NT; k++) begin
            if (sc_q == 4'(k)) t[k] = 1'b1;
        end
    end

    assign sc = sc_q;
endmodule

// File: rtl/mano_control_unit.sv
// mano_control_unit: hardwired control sequencer for the 16-bit basic
// computer. Owns SC (in mano_seq_counter), the run flag S and the indirect
// flag I; decodes IR and the T-state into bus/ALU/register/memory/E strobes.
//   CLK, RST_N : clock, async active-low reset (SC=0, S=1, I=0)
//   cu         : control bundle (master side), see mano_control_unit_if
// All strobes are combinational from SC/S/I, IR and status, and forced to 0
// while RST_N is low.
module mano_control_unit
    import mano_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    mano_control_unit_if.master  cu
);
    logic          s_q, s_d;
    logic          i_q, i_d;
    logic          sc_clr, sc_hold;
    logic [3:0]    sc;
    logic [NT-1:0] t;
    opcode_e       opc;
    logic [11:0]   rr;

    alu_sel_e      alu_sel;
    logic [2:0]    bus_sel;
    logic [4:0]    reg_ld;
    logic [3:0]    reg_inr;
    logic          ac_clr, mem_rd, mem_wr;
    e_op_e         e_op;

    mano_seq_counter u_sc (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (sc_clr),
        .hold  (sc_hold),
        .sc    (sc),
        .t     (t)
    );

    assign opc = opcode_e'(cu.IR[W-2:W-4]);
    assign rr  = rr_pick(cu.IR[11:0]);

    always_comb begin
        s_d     = s_q;
        i_d     = i_q;
        sc_clr  = 1'b0;
        sc_hold = 1'b0;
        alu_sel = ALU_ADD;
        bus_sel = BUS_NONE;
        reg_ld  = '0;
        reg_inr = '0;
        ac_clr  = 1'b0;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        e_op    = E_HOLD;

        if (!s_q) begin
            // Halted: SC frozen, only START does anything.
            sc_hold = 1'b1;
            if (cu.START) begin
                s_d    = 1'b1;
                sc_clr = 1'b1;
            end
        end else if (t[0]) begin
            bus_sel       = BUS_PC;
            reg_ld[LD_AR] = 1'b1;
        end else if (t[1]) begin
            mem_rd          = 1'b1;
            bus_sel         = BUS_MEM;
            reg_ld[LD_IR]   = 1'b1;
            reg_inr[INR_PC] = 1'b1;
        end else if (t[2]) begin
            i_d           = cu.IR[W-1];
            bus_sel       = BUS_IR;
            reg_ld[LD_AR] = 1'b1;
        end else if (t[3]) begin
            if (opc == OP_REG_IO) begin
                sc_clr = 1'b1;
                // I=1 is the I/O group, treated as NOP here.
                if (!i_q) begin
                    if (rr[11]) ac_clr = 1'b1;
                    if (rr[10]) e_op = E_CLR;
                    if (rr[9]) begin
                        alu_sel       = ALU_CMA;
                        reg_ld[LD_AC] = 1'b1;
                    end
                    if (rr[8]) e_op = E_CMP;
                    if (rr[7]) begin
                        alu_sel       = ALU_SHR;
                        reg_ld[LD_AC] = 1'b1;
                        e_op          = E_LD_AC0;
                    end
                    if (rr[6]) begin
                        alu_sel       = ALU_SHL;
                        reg_ld[LD_AC] = 1'b1;
                        e_op          = E_LD_ACMS;
                    end
                    if (rr[5]) reg_inr[INR_AC] = 1'b1;
                    if (rr[4] && !cu.AC_MSB)  reg_inr[INR_PC] = 1'b1;
                    if (rr[3] &&  cu.AC_MSB)  reg_inr[INR_PC] = 1'b1;
                    if (rr[2] &&  cu.AC_ZERO) reg_inr[INR_PC] = 1'b1;
                    if (rr[1] && !cu.E)       reg_inr[INR_PC] = 1'b1;
                    if (rr[0]) s_d = 1'b0;
                end
            end else if (i_q) begin
                // Indirect: AR <- M[AR]
                mem_rd        = 1'b1;
                bus_sel       = BUS_MEM;
                reg_ld[LD_AR] = 1'b1;
            end
        end else if (t[4]) begin
            unique case (opc)
                OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                    mem_rd        = 1'b1;
                    bus_sel       = BUS_MEM;
                    reg_ld[LD_DR] = 1'b1;
                end
                OP_STA: begin
                    bus_sel = BUS_AC;
                    mem_wr  = 1'b1;
                    sc_clr  = 1'b1;
                end
                OP_BUN: begin
                    bus_sel       = BUS_AR;
                    reg_ld[LD_PC] = 1'b1;
                    sc_clr        = 1'b1;
                end
                OP_BSA: begin
                    bus_sel         = BUS_PC;
                    mem_wr          = 1'b1;
                    reg_inr[INR_AR] = 1'b1;
                end
                default: ;
            endcase
        end else if (t[5]) begin
            unique case (opc)
                OP_AND: begin
                    alu_sel       = ALU_AND;
                    reg_ld[LD_AC] = 1'b1;
                    sc_clr        = 1'b1;
                end
                OP_ADD: begin
                    alu_sel       = ALU_ADD;
                    reg_ld[LD_AC] = 1'b1;
                    e_op          = E_LD_CO;
                    sc_clr        = 1'b1;
                end
                OP_LDA: begin
                    alu_sel       = ALU_XFER;
                    reg_ld[LD_AC] = 1'b1;
                    sc_clr        = 1'b1;
                end
                OP_BSA: begin
                    bus_sel       = BUS_AR;
                    reg_ld[LD_PC] = 1'b1;
                    sc_clr        = 1'b1;
                end
                OP_ISZ: reg_inr[INR_DR] = 1'b1;
                default: ;
            endcase
        end else if (t[6]) begin
            if (opc == OP_ISZ) begin
                bus_sel         = BUS_DR;
                mem_wr          = 1'b1;
                reg_inr[INR_PC] = cu.DR_ZERO;
                sc_clr          = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s_q <= 1'b1;
            i_q <= 1'b0;
        end else begin
            s_q <= s_d;
            i_q <= i_d;
        end
    end

    // Reset state is T0 with S=1, which would otherwise show fetch strobes.
    assign cu.ALU_SEL = RST_N ? alu_sel : 3'd0;
    assign cu.BUS_SEL = RST_N ? bus_sel : 3'd0;
    assign cu.REG_LD  = RST_N ? reg_ld  : 5'd0;
    assign cu.REG_INR = RST_N ? reg_inr : 4'd0;
    assign cu.AC_CLR  = RST_N & ac_clr;
    assign cu.MEM_RD  = RST_N & mem_rd;
    assign cu.MEM_WR  = RST_N & mem_wr;
    assign cu.E_OP    = RST_N ? e_op    : 3'd0;
    assign cu.HALTED  = ~s_q;
    assign cu.SC_OUT  = sc;
endmodule

// File: tb/tb_mano_control_unit.sv
module tb_mano_control_unit;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    mano_control_unit_if #(.W(16)) cif ();

    mano_control_unit #(.W(16)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .cu    (cif)
    );

    always #5 CLK = ~CLK;

    // snapshot = {alu,bus,ld,inr,clr,rd,wr,eop,halted,sc}
    logic [25:0] exp_q[$];
    string       nm_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;

    function automatic logic [25:0] mk(input logic [2:0] alu, input logic [2:0] bsel,
                                       input logic [4:0] ld, input logic [3:0] inr,
                                       input logic clr, input logic rd, input logic wr,
                                       input logic [2:0] eop, input logic halt,
                                       input logic [3:0] sc);
        return {alu, bsel, ld, inr, clr, rd, wr, eop, halt, sc};
    endfunction

    function automatic logic [25:0] idle(input logic halt, input logic [3:0] sc);
        return mk(3'd0, 3'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd0, halt, sc);
    endfunction

    // Monitor: compares the DUT against the oldest pending expectation
    // mid-cycle, away from the rising edge.
    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            logic [25:0] e, a;
            string       n;
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            a = {cif.ALU_SEL, cif.BUS_SEL, cif.REG_LD, cif.REG_INR, cif.AC_CLR,
                 cif.MEM_RD, cif.MEM_WR, cif.E_OP, cif.HALTED, cif.SC_OUT};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL %s: got %h expected %h", n, a, e);
        end
    end

    task automatic cyc(input logic [15:0] ir, input logic st,
                       input logic [25:0] e, input string nm);
        cif.IR    = ir;
        cif.START = st;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge CLK);
        #1;
        cif.START = 1'b0;
    endtask

    task automatic fetch(input logic [15:0] ir, input string tag);
        cyc(ir, 1'b0, mk(3'd0, 3'd2, 5'b00001, 4'b0000, 0, 0, 0, 3'd0, 0, 4'd0), {tag, "_T0"});
        cyc(ir, 1'b0, mk(3'd0, 3'd7, 5'b10000, 4'b0010, 0, 1, 0, 3'd0, 0, 4'd1), {tag, "_T1"});
        cyc(ir, 1'b0, mk(3'd0, 3'd5, 5'b00001, 4'b0000, 0, 0, 0, 3'd0, 0, 4'd2), {tag, "_T2"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.START   = 1'b0;
        cif.IR      = 16'h0000;
        cif.AC_ZERO = 1'b0;
        cif.AC_MSB  = 1'b0;
        cif.E       = 1'b0;
        cif.DR_ZERO = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        cyc(16'h0000, 1'b0, idle(0, 4'd0), "reset_outputs");
        RST_N = 1'b1;

        // ADD direct
        fetch(16'h1005, "add");
        cyc(16'h1005, 0, idle(0, 4'd3), "add_T3");
        cyc(16'h1005, 0, mk(3'd0, 3'd7, 5'b00100, 4'd0, 0, 1, 0, 3'd0, 0, 4'd4), "add_T4");
        cyc(16'h1005, 0, mk(3'd0, 3'd0, 5'b01000, 4'd0, 0, 0, 0, 3'd3, 0, 4'd5), "add_T5");

        // AND indirect
        fetch(16'h8005, "and_ind");
        cyc(16'h8005, 0, mk(3'd0, 3'd7, 5'b00001, 4'd0, 0, 1, 0, 3'd0, 0, 4'd3), "and_ind_T3");
        cyc(16'h8005, 0, mk(3'd0, 3'd7, 5'b00100, 4'd0, 0, 1, 0, 3'd0, 0, 4'd4), "and_ind_T4");
        cyc(16'h8005, 0, mk(3'd1, 3'd0, 5'b01000, 4'd0, 0, 0, 0, 3'd0, 0, 4'd5), "and_ind_T5");

        // ISZ, DR becomes zero -> skip
        cif.DR_ZERO = 1'b1;
        fetch(16'h6010, "isz_skip");
        cyc(16'h6010, 0, idle(0, 4'd3), "isz_skip_T3");
        cyc(16'h6010, 0, mk(3'd0, 3'd7, 5'b00100, 4'd0, 0, 1, 0, 3'd0, 0, 4'd4), "isz_skip_T4");
        cyc(16'h6010, 0, mk(3'd0, 3'd0, 5'b00000, 4'b0100, 0, 0, 0, 3'd0, 0, 4'd5), "isz_skip_T5");
        cyc(16'h6010, 0, mk(3'd0, 3'd3, 5'b00000, 4'b0010, 0, 0, 1, 3'd0, 0, 4'd6), "isz_skip_T6");

        // ISZ, DR nonzero -> no skip
        cif.DR_ZERO = 1'b0;
        fetch(16'h6010, "isz_noskip");
        cyc(16'h6010, 0, idle(0, 4'd3), "isz_noskip_T3");
        cyc(16'h6010, 0, mk(3'd0, 3'd7, 5'b00100, 4'd0, 0, 1, 0, 3'd0, 0, 4'd4), "isz_noskip_T4");
        cyc(16'h6010, 0, mk(3'd0, 3'd0, 5'b00000, 4'b0100, 0, 0, 0, 3'd0, 0, 4'd5), "isz_noskip_T5");
        cyc(16'h6010, 0, mk(3'd0, 3'd3, 5'b00000, 4'b0000, 0, 0, 1, 3'd0, 0, 4'd6), "isz_noskip_T6");

        // CIR
        fetch(16'h7080, "cir");
        cyc(16'h7080, 0, mk(3'd4, 3'd0, 5'b01000, 4'd0, 0, 0, 0, 3'd4, 0, 4'd3), "cir_T3");

        // SZA with AC==0 -> skip, AC!=0 -> nothing
        cif.AC_ZERO = 1'b1;
        fetch(16'h7004, "sza_z");
        cyc(16'h7004, 0, mk(3'd0, 3'd0, 5'd0, 4'b0010, 0, 0, 0, 3'd0, 0, 4'd3), "sza_z_T3");
        cif.AC_ZERO = 1'b0;
        fetch(16'h7004, "sza_nz");
        cyc(16'h7004, 0, idle(0, 4'd3), "sza_nz_T3");

        // STA and BSA
        fetch(16'h3000, "sta");
        cyc(16'h3000, 0, idle(0, 4'd3), "sta_T3");
        cyc(16'h3000, 0, mk(3'd0, 3'd4, 5'd0, 4'd0, 0, 0, 1, 3'd0, 0, 4'd4), "sta_T4");
        fetch(16'h5000, "bsa");
        cyc(16'h5000, 0, idle(0, 4'd3), "bsa_T3");
        cyc(16'h5000, 0, mk(3'd0, 3'd2, 5'd0, 4'b0001, 0, 0, 1, 3'd0, 0, 4'd4), "bsa_T4");
        cyc(16'h5000, 0, mk(3'd0, 3'd1, 5'b00010, 4'd0, 0, 0, 0, 3'd0, 0, 4'd5), "bsa_T5");

        // CLA+INC together: highest bit (CLA) wins
        fetch(16'h7820, "multi_rr");
        cyc(16'h7820, 0, mk(3'd0, 3'd0, 5'd0, 4'd0, 1, 0, 0, 3'd0, 0, 4'd3), "multi_rr_T3");

        // START while running is ignored (CMA proceeds normally)
        cyc(16'h7200, 1, mk(3'd0, 3'd2, 5'b00001, 4'b0000, 0, 0, 0, 3'd0, 0, 4'd0), "cma_T0_start");
        cyc(16'h7200, 1, mk(3'd0, 3'd7, 5'b10000, 4'b0010, 0, 1, 0, 3'd0, 0, 4'd1), "cma_T1_start");
        cyc(16'h7200, 0, mk(3'd0, 3'd5, 5'b00001, 4'b0000, 0, 0, 0, 3'd0, 0, 4'd2), "cma_T2");
        cyc(16'h7200, 0, mk(3'd3, 3'd0, 5'b01000, 4'd0, 0, 0, 0, 3'd0, 0, 4'd3), "cma_T3");

        // HLT with START in the same cycle: HLT wins
        fetch(16'h7001, "hlt");
        cyc(16'h7001, 1, idle(0, 4'd3), "hlt_T3_start");
        for (int k = 0; k < 10; k++) cyc(16'h7001, 0, idle(1, 4'd0), "halted_idle");
        cyc(16'h7001, 1, idle(1, 4'd0), "halted_start_cycle");
        fetch(16'h2000, "restart_lda");
        cyc(16'h2000, 0, idle(0, 4'd3), "lda_T3");
        cyc(16'h2000, 0, mk(3'd0, 3'd7, 5'b00100, 4'd0, 0, 1, 0, 3'd0, 0, 4'd4), "lda_T4");
        cyc(16'h2000, 0, mk(3'd2, 3'd0, 5'b01000, 4'd0, 0, 0, 0, 3'd0, 0, 4'd5), "lda_T5");

        // Reset in the middle of an ADD
        fetch(16'h1005, "add_rst");
        cyc(16'h1005, 0, idle(0, 4'd3), "add_rst_T3");
        RST_N = 1'b0;
        cyc(16'h1005, 0, idle(0, 4'd0), "midreset_outputs");
        RST_N = 1'b1;
        fetch(16'h4123, "bun_after_rst");
        cyc(16'h4123, 0, idle(0, 4'd3), "bun_T3");
        cyc(16'h4123, 0, mk(3'd0, 3'd1, 5'b00010, 4'd0, 0, 0, 0, 3'd0, 0, 4'd4), "bun_T4");
        fetch(16'h0000, "after_bun");

        begin
            int guard;
            guard = 0;
            while (exp_q.size() != 0 && guard < 20) begin
                @(posedge CLK);
                guard++;
            end
            if (exp_q.size() != 0) begin
                n_chk++;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
